// File: rtl/lock_code_sender_pkg.sv
// Shared constants for both ends of the serial combination-lock link.
// CODE_LEN and HOLD_CYCLES defaults match the lock's code length and unlock window.
package lock_code_sender_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int unsigned DEF_CODE_LEN    = 4;
  localparam int unsigned DEF_HOLD_CYCLES = 10;

  // Width of a counter that must hold values 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lock_code_sender_shift.sv
// Loadable MSB-first shift register with registered serial bit, valid flag and 1-based bit index.
module lock_shift_out #(
  parameter int unsigned CODE_LEN   = 4,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load,
  input  logic                         shift,
  input  logic [CODE_LEN-1:0]          code,
  output logic                         x_out,
  output logic                         tx_valid,
  output logic [$clog2(CODE_LEN+1)-1:0] bit_idx
);

  localparam int unsigned IW = $clog2(CODE_LEN + 1);

  logic [CODE_LEN-1:0] sr;

  // The MSB goes straight to x_out on load; sr keeps the remaining bits left-aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr       <= '0;
      x_out    <= IDLE_LEVEL;
      tx_valid <= 1'b0;
      bit_idx  <= '0;
    end else if (load) begin
      sr       <= code << 1;
      x_out    <= code[CODE_LEN-1];
      tx_valid <= 1'b1;
      bit_idx  <= IW'(1);
    end else if (shift) begin
      sr       <= sr << 1;
      x_out    <= sr[CODE_LEN-1];
      tx_valid <= 1'b1;
      bit_idx  <= bit_idx + 1'b1;
    end else begin
      sr       <= '0;
      x_out    <= IDLE_LEVEL;
      tx_valid <= 1'b0;
      bit_idx  <= '0;
    end
  end

endmodule

// File: rtl/lock_code_sender.sv
// Serial code transmitter for the combination lock: sends CODE_LEN bits MSB first,
// holds the line idle for HOLD_CYCLES, then pulses done for one cycle.
module lock_code_sender
  import lock_code_sender_pkg::*;
#(
  parameter int unsigned CODE_LEN    = DEF_CODE_LEN,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter logic        IDLE_LEVEL  = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [CODE_LEN-1:0]           code,
  input  logic                          abort,
  output logic                          x_out,
  output logic                          tx_valid,
  output logic [$clog2(CODE_LEN+1)-1:0] bit_idx,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned      IW        = $clog2(CODE_LEN + 1);
  localparam int unsigned      HW        = cnt_width(HOLD_CYCLES);
  localparam logic [IW-1:0]    LAST_IDX  = IW'(CODE_LEN);
  localparam logic [HW-1:0]    HOLD_INIT = HW'(HOLD_CYCLES);

  state_e        state;
  logic [HW-1:0] hold_cnt;
  logic          load;
  logic          shift;

  // Datapath controls; anything other than load/shift returns the line to idle.
  always_comb begin
    load  = 1'b0;
    shift = 1'b0;
    if (!abort) begin
      case (state)
        ST_IDLE: load  = start;
        ST_SEND: shift = (bit_idx != LAST_IDX);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state    <= ST_IDLE;
        hold_cnt <= '0;
        busy     <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state <= ST_SEND;
              busy  <= 1'b1;
            end
          end
          ST_SEND: begin
            if (bit_idx == LAST_IDX) begin
              if (HOLD_CYCLES == 0) begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state    <= ST_HOLD;
                hold_cnt <= HOLD_INIT;
              end
            end
          end
          ST_HOLD: begin
            // Counter runs HOLD_CYCLES..1; a stray 0 also exits rather than wrapping.
            if (hold_cnt <= HW'(1)) begin
              state    <= ST_DONE;
              hold_cnt <= '0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt - 1'b1;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

  lock_shift_out #(
    .CODE_LEN  (CODE_LEN),
    .IDLE_LEVEL(IDLE_LEVEL)
  ) u_shift (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .shift   (shift),
    .code    (code),
    .x_out   (x_out),
    .tx_valid(tx_valid),
    .bit_idx (bit_idx)
  );

endmodule
